// File: rtl/slow_tick_timer_pkg.sv
// Shared types and default parameters for the slow-clock tick timer.
package slow_tick_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_WD_LIMIT    = 150000000;

endpackage

// File: rtl/slow_tick_timer_if.sv
// Control/status bundle between a phase sequencer and the slow tick timer.
interface slow_tick_timer_if
    import slow_tick_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic             slow_in;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             pause;
    logic             tick;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output slow_in, load, load_val, pause,
        input  tick, remaining, busy, done, stall
    );

    modport slave (
        input  slow_in, load, load_val, pause,
        output tick, remaining, busy, done, stall
    );
endinterface

// File: rtl/slow_tick_timer_tick_sync.sv
// Brings the divided slow clock into clk and emits one registered tick per
// rising edge, with an arm flag so a level held high through reset is ignored.
module tick_sync
    import slow_tick_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic slow_in,
    output logic tick
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   hist_q;
    logic                   armed_q;
    logic                   sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // fill_q marks when the last stage holds a real sample rather than its
    // reset zero; without it the reset value would count as a low and arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            fill_q  <= '0;
            hist_q  <= 1'b0;
            armed_q <= 1'b0;
            tick    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], slow_in};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            hist_q  <= sync_last;
            if (fill_q[SYNC_STAGES-1] && !sync_last)
                armed_q <= 1'b1;
            tick    <= armed_q && sync_last && !hist_q;
        end
    end
endmodule

// File: rtl/slow_tick_timer.sv
// Countdown of synchronized slow-clock ticks with done pulse and stall watchdog.
//   state   | meaning
//   IDLE    | no countdown active, waiting for load
//   RUN     | counting ticks down toward zero
module slow_tick_timer
    import slow_tick_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned WD_LIMIT    = DEF_WD_LIMIT
) (
    input  logic               clk,
    input  logic               rst,
    slow_tick_timer_if.slave   bus
);
    localparam logic [31:0] WD_MAX = 32'(WD_LIMIT);

    logic             tick;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic [31:0]      wd_q, wd_d;
    logic             stall_q;

    tick_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick_sync (
        .clk     (clk),
        .rst     (rst),
        .slow_in (bus.slow_in),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // load is handled identically in both states and beats a same-cycle tick.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (bus.load) begin
            if (bus.load_val != '0) begin
                rem_d   = bus.load_val;
                state_d = ST_RUN;
            end else begin
                rem_d   = '0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (tick && !bus.pause) begin
                        if (rem_q <= CNT_W'(1)) begin
                            rem_d   = '0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            rem_d = rem_q - CNT_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wd_d = wd_q;
        if (tick)
            wd_d = '0;
        else if (wd_q < WD_MAX)
            wd_d = wd_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q    <= '0;
            stall_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            stall_q <= (wd_d >= WD_MAX);
        end
    end

    assign bus.tick      = tick;
    assign bus.remaining = rem_q;
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = done_q;
    assign bus.stall     = stall_q;
endmodule

// File: tb/tb_slow_tick_timer.sv
// Directed bench for slow_tick_timer: sync/arm, countdown, pause, restart, zero load, watchdog, reset.
module tb_slow_tick_timer;
    logic clk = 1'b0;
    logic rst;
    logic slow_en;
    logic slow_level;
    int   tests = 0;
    int   fails = 0;

    slow_tick_timer_if #(.CNT_W(8)) bus();

    slow_tick_timer #(
        .SYNC_STAGES (2),
        .CNT_W       (8),
        .WD_LIMIT    (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Slow clock source: toggles every 8 fast cycles when enabled, else holds slow_level.
    initial begin : slow_gen
        int cnt;
        cnt = 0;
        bus.slow_in = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (slow_en) begin
                cnt++;
                if (cnt == 8) begin
                    bus.slow_in = ~bus.slow_in;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
                bus.slow_in = slow_level;
            end
        end
    end

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_tick: tick=0 for 60 cycles, expected a tick");
        end
    endtask

    task automatic test_reset;
        int nt;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.tick, bus.busy, bus.done, bus.stall} !== 4'b0000 || bus.remaining !== 8'd0) begin
            fails++;
            $display("FAIL reset_vals: tick=%b busy=%b done=%b stall=%b rem=%0d, expected all 0",
                     bus.tick, bus.busy, bus.done, bus.stall, bus.remaining);
        end
        rst = 1'b0;
        nt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.tick === 1'b1) nt++;
        end
        tests++;
        if (nt != 0) begin
            fails++;
            $display("FAIL no_spurious_tick: %0d ticks, expected 0", nt);
        end
        slow_level = 1'b0;
        repeat (5) @(negedge clk);
        slow_level = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            tests++;
            if (bus.tick !== 1'(i == 3)) begin
                fails++;
                $display("FAIL tick_latency: cycle %0d tick=%b expected %b", i, bus.tick, i == 3);
            end
        end
    endtask

    task automatic test_countdown;
        bit ok;
        slow_en = 1'b1;
        wait_tick(ok);
        bus.load = 1'b1;
        bus.load_val = 8'd3;
        @(negedge clk);
        bus.load = 1'b0;
        tests++;
        if (bus.busy !== 1'b1 || bus.remaining !== 8'd3) begin
            fails++;
            $display("FAIL cd_load: busy=%b rem=%0d expected busy=1 rem=3", bus.busy, bus.remaining);
        end
        for (int i = 1; i <= 3; i++) begin
            wait_tick(ok);
            @(negedge clk);
            tests++;
            if (bus.remaining !== 8'(3 - i) || bus.done !== 1'(i == 3) || bus.busy !== 1'(i != 3)) begin
                fails++;
                $display("FAIL cd_step%0d: rem=%0d done=%b busy=%b expected rem=%0d done=%b busy=%b",
                         i, bus.remaining, bus.done, bus.busy, 3 - i, i == 3, i != 3);
            end
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("FAIL cd_done_once: done=%b expected 0", bus.done);
        end
    endtask

    task automatic test_pause_restart;
        bit ok;
        wait_tick(ok);
        bus.load = 1'b1;
        bus.load_val = 8'd4;
        @(negedge clk);
        bus.load = 1'b0;
        wait_tick(ok);
        @(negedge clk);
        tests++;
        if (bus.remaining !== 8'd3) begin
            fails++;
            $display("FAIL pr_first: rem=%0d expected 3", bus.remaining);
        end
        bus.pause = 1'b1;
        wait_tick(ok);
        @(negedge clk);
        bus.pause = 1'b0;
        tests++;
        if (bus.remaining !== 8'd3 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL pr_paused: rem=%0d busy=%b expected rem=3 busy=1", bus.remaining, bus.busy);
        end
        wait_tick(ok);
        bus.load = 1'b1;
        bus.load_val = 8'd2;
        @(negedge clk);
        bus.load = 1'b0;
        tests++;
        if (bus.remaining !== 8'd2 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL pr_restart: rem=%0d done=%b busy=%b expected rem=2 done=0 busy=1",
                     bus.remaining, bus.done, bus.busy);
        end
        wait_tick(ok);
        @(negedge clk);
        tests++;
        if (bus.remaining !== 8'd1) begin
            fails++;
            $display("FAIL pr_rem1: rem=%0d expected 1", bus.remaining);
        end
        wait_tick(ok);
        @(negedge clk);
        tests++;
        if (bus.remaining !== 8'd0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL pr_done: rem=%0d done=%b busy=%b expected rem=0 done=1 busy=0",
                     bus.remaining, bus.done, bus.busy);
        end
    endtask

    task automatic test_final_tick;
        bit ok;
        wait_tick(ok);
        bus.load = 1'b1;
        bus.load_val = 8'd1;
        @(negedge clk);
        bus.load = 1'b0;
        wait_tick(ok);
        bus.load = 1'b1;
        bus.load_val = 8'd3;
        @(negedge clk);
        bus.load = 1'b0;
        tests++;
        if (bus.remaining !== 8'd3 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL ft_load_wins: rem=%0d done=%b busy=%b expected rem=3 done=0 busy=1",
                     bus.remaining, bus.done, bus.busy);
        end
        wait_tick(ok);
        bus.load = 1'b1;
        bus.load_val = 8'd1;
        @(negedge clk);
        bus.load = 1'b0;
        bus.pause = 1'b1;
        wait_tick(ok);
        @(negedge clk);
        bus.pause = 1'b0;
        tests++;
        if (bus.remaining !== 8'd1 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL ft_paused_final: rem=%0d done=%b busy=%b expected rem=1 done=0 busy=1",
                     bus.remaining, bus.done, bus.busy);
        end
        wait_tick(ok);
        @(negedge clk);
        tests++;
        if (bus.remaining !== 8'd0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL ft_unpaused_final: rem=%0d done=%b busy=%b expected rem=0 done=1 busy=0",
                     bus.remaining, bus.done, bus.busy);
        end
    endtask

    task automatic test_zero_load;
        @(negedge clk);
        bus.load = 1'b1;
        bus.load_val = 8'd0;
        @(negedge clk);
        bus.load = 1'b0;
        tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.remaining !== 8'd0) begin
            fails++;
            $display("FAIL zl_idle: done=%b busy=%b rem=%0d expected done=1 busy=0 rem=0",
                     bus.done, bus.busy, bus.remaining);
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("FAIL zl_pulse_len: done=%b expected 0", bus.done);
        end
        bus.load = 1'b1;
        bus.load_val = 8'd5;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.remaining !== 8'd5) begin
            fails++;
            $display("FAIL zl_load5: busy=%b rem=%0d expected busy=1 rem=5", bus.busy, bus.remaining);
        end
        bus.load_val = 8'd0;
        @(negedge clk);
        bus.load = 1'b0;
        tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.remaining !== 8'd0) begin
            fails++;
            $display("FAIL zl_run: done=%b busy=%b rem=%0d expected done=1 busy=0 rem=0",
                     bus.done, bus.busy, bus.remaining);
        end
    endtask

    task automatic test_watchdog;
        bit ok;
        wait_tick(ok);
        slow_en = 1'b0;
        slow_level = 1'b1;
        bus.load = 1'b1;
        bus.load_val = 8'd2;
        for (int j = 1; j <= 25; j++) begin
            @(negedge clk);
            bus.load = 1'b0;
            if (j == 20) begin
                tests++;
                if (bus.stall !== 1'b0) begin
                    fails++;
                    $display("FAIL wd_early: stall=%b after 19 idle cycles, expected 0", bus.stall);
                end
            end
            if (j == 21) begin
                tests++;
                if (bus.stall !== 1'b1) begin
                    fails++;
                    $display("FAIL wd_rise: stall=%b after 20 idle cycles, expected 1", bus.stall);
                end
            end
        end
        tests++;
        if (bus.stall !== 1'b1 || bus.busy !== 1'b1 || bus.remaining !== 8'd2) begin
            fails++;
            $display("FAIL wd_hold: stall=%b busy=%b rem=%0d expected stall=1 busy=1 rem=2",
                     bus.stall, bus.busy, bus.remaining);
        end
        slow_en = 1'b1;
        wait_tick(ok);
        tests++;
        if (bus.stall !== 1'b1) begin
            fails++;
            $display("FAIL wd_tick_cycle: stall=%b expected 1", bus.stall);
        end
        @(negedge clk);
        tests++;
        if (bus.stall !== 1'b0 || bus.remaining !== 8'd1) begin
            fails++;
            $display("FAIL wd_clear: stall=%b rem=%0d expected stall=0 rem=1", bus.stall, bus.remaining);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int nd;
        wait_tick(ok);
        bus.load = 1'b1;
        bus.load_val = 8'd5;
        @(negedge clk);
        bus.load = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            wait_tick(ok);
            @(negedge clk);
            tests++;
            if (bus.remaining !== 8'(5 - i)) begin
                fails++;
                $display("FAIL rm_step%0d: rem=%0d expected %0d", i, bus.remaining, 5 - i);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({bus.tick, bus.busy, bus.done, bus.stall} !== 4'b0000 || bus.remaining !== 8'd0) begin
            fails++;
            $display("FAIL rm_reset: tick=%b busy=%b done=%b stall=%b rem=%0d expected all 0",
                     bus.tick, bus.busy, bus.done, bus.stall, bus.remaining);
        end
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) nd++;
        end
        tests++;
        if (nd != 0) begin
            fails++;
            $display("FAIL rm_quiet: %0d cycles with done/busy high, expected 0", nd);
        end
    endtask

    initial begin
        rst          = 1'b1;
        slow_en      = 1'b0;
        slow_level   = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = 8'd0;
        bus.pause    = 1'b0;
        test_reset;
        test_countdown;
        test_pause_restart;
        test_final_tick;
        test_zero_load;
        test_watchdog;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/slow_tick_timer.md
# slow_tick_timer

Fast-domain consumer of the divided slow clock. Synchronizes the slow clock into `clk`, converts each slow rising edge into a one-cycle `tick`, and runs a loadable countdown of ticks with a completion pulse, for timing traffic-light phases. A watchdog flags a stalled or missing slow clock.

## Interface
- `SYNC_STAGES`, 2, synchronizer flop count, minimum 2.
- `CNT_W`, 8, width of the countdown value in ticks.
- `WD_LIMIT`, 150000000, fast cycles without a tick before `stall` asserts. Must be at least 2 and fit in 32 bits.

- `clk` in 1: fast system clock.
- `rst` in 1: reset, synchronous, active-high.
- `slow_in` in 1: divided slow clock, asynchronous to `clk`, treated as data.
- `load` in 1: start or restart the countdown with `load_val`.
- `load_val` in CNT_W: phase length in ticks.
- `pause` in 1: while high, ticks do not decrement.
- `tick` out 1: one-cycle pulse per synchronized slow rising edge.
- `remaining` out CNT_W: ticks left.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when the countdown reaches 0.
- `stall` out 1: watchdog flag.

## Operation
- **Synchronizer**
  - `slow_in` passes through SYNC_STAGES flops, then one history flop for edge detection.
  - A rising edge is "last sync stage high, history low".
- **Arm flag**
  - Cleared by reset.
  - Set on the first sampled low at the last sync stage.
  - `tick` is suppressed while the flag is clear, so `slow_in` held high through reset produces no spurious tick.
- **FSM states:** IDLE, RUN.
- **IDLE**
  - `load` with `load_val`≠0: `remaining`=`load_val`, go to RUN.
  - `load` with `load_val`=0: `done` pulses, stay in IDLE, `remaining`=0.
- **RUN**
  - `load` has priority over a same-cycle tick and restarts with `load_val`. `load_val`=0 here gives `done` and a return to IDLE.
  - Else, on `tick`&&!`pause`:
    - if `remaining`==1: `remaining`=0, `done` pulses, go to IDLE;
    - otherwise `remaining` decrements.
  - A tick while `pause` is high is dropped, not deferred.
- **Watchdog**
  - 32-bit counter of fast cycles since the last `tick` (armed or not irrelevant: it counts raw qualified ticks only). It saturates at WD_LIMIT.
  - `stall`=1 while the counter ≥ WD_LIMIT.
  - A `tick` clears the counter to 0 and deasserts `stall` in the next cycle.
  - The watchdog is independent of FSM state.
- **Arithmetic:** unsigned only, no wrap. `remaining` never decrements below 0.

## Timing
- **Reset values:** `tick`=0, `remaining`=0, `busy`=0, `done`=0, `stall`=0. State IDLE, arm clear, sync chain and history 0, watchdog counter 0.
- **Tick latency:** all outputs are registered. If `slow_in` is first sampled high at edge k, `tick` is high for exactly the cycle following edge k+SYNC_STAGES (2 cycles of sync plus 1 of register).
- **Load latency:** `load` sampled at edge k → `busy`=1 and `remaining`=`load_val` after edge k.
- **Countdown:** `remaining` updates in the cycle after the edge at which `tick` is sampled high. `done` and the `busy` fall occur in that same cycle.
- **Duration:** a countdown of N with no pause completes on the N-th tick after load.
- **`rst` mid-countdown:** immediate return to reset values. No `done` is emitted.
- **`load` coincident with the final tick:** the restart wins and no `done` is emitted.
- **`pause` held across the final tick:** no completion until a later unpaused tick.
- **Slow clock stops high or low:** `stall` rises after WD_LIMIT cycles. The FSM holds.

## Structure
- **Package `slow_tick_pkg`:**
  - FSM state enum (IDLE, RUN);
  - default constants for SYNC_STAGES, CNT_W, WD_LIMIT.
- **Sub-module `tick_sync`:**
  - synchronizer chain, history flop, arm flag, registered `tick`;
  - parameter SYNC_STAGES.
- **Top level:** FSM, countdown register, and watchdog.

## Test plan
- **Reset with slow input high:** `slow_in` held high through reset and 10 cycles after → no `tick`. Then low 5 cycles and high → exactly one `tick`, 3 cycles after the rise (SYNC_STAGES=2).
- **Basic countdown:** load 3, with `slow_in` toggling every 8 cycles → `remaining` 3→2→1→0. `done` pulses once on the 3rd tick, `busy` falls in the same cycle.
- **Pause and restart:** load 4, with `pause` held across the 2nd tick → `remaining` stays 3. Then `load` 2 coincident with a tick → `remaining`=2, no `done`.
- **Zero load:** `load`=1 with `load_val`=0 in IDLE → `done` pulses for one cycle, `busy` stays 0, `remaining`=0.
- **Watchdog:** WD_LIMIT=20, slow clock stopped → `stall`=1 after 20 cycles. Restart the clock → `stall`=0 the cycle after the next `tick`.
- **Reset mid-run:** load 5, 2 ticks, then `rst` for 1 cycle → all outputs 0 next cycle, no `done`.
